// File: rtl/rsa_modexp.sv
// ---------------------------------------------------------------------------
// rsa_modexp -- modular exponentiation engine, result = base^exponent mod modulus
//
// Left-to-right square-and-multiply. Each modular product R*B mod N is built
// bit-serially with interleaved shift/add/reduce, one multiplier bit of R per
// enabled clock, MSB first.
//
// Ports
//   clk       in   system clock
//   rstb      in   asynchronous active-low reset
//   ena       in   global clock enable; every register holds when 0
//   en        in   unit enable; 0 forces IDLE
//   clear     in   0 = hold cleared and load operands, 1 = run
//   base      in   message M        (WIDTH bits)
//   exponent  in   exponent E       (WIDTH bits)
//   modulus   in   modulus N        (WIDTH bits)
//   eoc       out  end of conversion (level, held in DONE)
//   result    out  M^E mod N, updated only on entry to DONE
// ---------------------------------------------------------------------------
module rsa_modexp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             eoc,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQUARE,
        S_MULT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;        // captured message
    logic [WIDTH-1:0] e_q, e_d;        // captured exponent
    logic [WIDTH-1:0] n_q, n_d;        // captured modulus
    logic [WIDTH-1:0] r_q, r_d;        // running result R
    logic [WIDTH-1:0] p_q, p_d;        // partial product of the current modmul
    logic [CW-1:0]    idx_q, idx_d;    // exponent bit index i
    logic [CW-1:0]    cnt_q, cnt_d;    // multiplier bit index within a modmul
    logic             eoc_q, eoc_d;
    logic [WIDTH-1:0] result_q, result_d;

    // ------------------------------------------------------------------
    // One shift/add/reduce step. R is always the multiplier; the
    // multiplicand is R itself for squaring and M for the multiply step.
    // Both P and the multiplicand are < N, so every intermediate stays
    // below 2N and fits in WIDTH+1 bits.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   acc_red;
    logic [WIDTH-1:0] p_next;

    always_comb begin
        mcand   = (state_q == S_MULT) ? m_q : r_q;
        n_ext   = {1'b0, n_q};
        dbl     = {p_q, 1'b0};
        dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
        acc     = r_q[cnt_q] ? (dbl_red + {1'b0, mcand}) : dbl_red;
        acc_red = (acc >= n_ext) ? (acc - n_ext) : acc;
        p_next  = acc_red[WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        n_d      = n_q;
        r_d      = r_q;
        p_d      = p_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        eoc_d    = eoc_q;
        result_d = result_q;

        if (!en) begin
            state_d = S_IDLE;
            eoc_d   = 1'b0;
        end else if (!clear) begin
            // Any cycle that leaves the unit in LOAD samples the operands,
            // including the cycle that enters LOAD, so the registers always
            // hold the values present on the last LOAD cycle before release.
            state_d = S_LOAD;
            eoc_d   = 1'b0;
            m_d     = base;
            e_d     = exponent;
            n_d     = modulus;
            r_d     = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
            p_d     = '0;
            idx_d   = CW'(WIDTH - 1);
            cnt_d   = CW'(WIDTH - 1);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    eoc_d = 1'b0;
                end

                S_LOAD: begin
                    if ((n_q == '0) || (m_q >= n_q)) begin
                        state_d  = S_DONE;
                        r_d      = '0;
                        result_d = '0;
                        eoc_d    = 1'b1;
                    end else begin
                        state_d = S_SQUARE;
                    end
                end

                S_SQUARE, S_MULT: begin
                    p_d   = p_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        r_d   = p_next;
                        p_d   = '0;
                        cnt_d = CW'(WIDTH - 1);
                        if ((state_q == S_SQUARE) && e_q[idx_q]) begin
                            state_d = S_MULT;
                        end else begin
                            state_d = S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    if (idx_q == '0) begin
                        state_d  = S_DONE;
                        result_d = r_q;
                        eoc_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SQUARE;
                    end
                end

                S_DONE: begin
                    eoc_d = 1'b1;
                end

                default: begin
                    state_d = S_IDLE;
                    eoc_d   = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            p_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            eoc_q    <= 1'b0;
            result_q <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            m_q      <= m_d;
            e_q      <= e_d;
            n_q      <= n_d;
            r_q      <= r_d;
            p_q      <= p_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            eoc_q    <= eoc_d;
            result_q <= result_d;
        end
    end

    assign eoc    = eoc_q;
    assign result = result_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// ---------------------------------------------------------------------------
// tb_rsa_modexp -- directed, table-driven bench for rsa_modexp (WIDTH=8).
// Latency is counted in enabled cycles from the first cycle after clear is
// released until eoc is seen high.
// ---------------------------------------------------------------------------
module tb_rsa_modexp;

    localparam int W      = 8;
    localparam int BUDGET = 2000;

    logic         clk;
    logic         rstb;
    logic         ena;
    logic         en;
    logic         clear;
    logic [W-1:0] base;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic         eoc;
    logic [W-1:0] result;

    int vectors;
    int miscompares;
    logic [W-1:0] last_res;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .ena      (ena),
        .en       (en),
        .clear    (clear),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .eoc      (eoc),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] e;
        logic [W-1:0] n;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Load operands, release clear, count enabled cycles to eoc, then check
    // result and that eoc/result are held while clear stays high.
    task automatic run_vec(input logic [W-1:0] m, input logic [W-1:0] e,
                           input logic [W-1:0] n, input logic [W-1:0] r_exp,
                           input int lat_exp, input bit stall);
        int n_en;
        int n_stall;
        en       = 1'b1;
        ena      = 1'b1;
        clear    = 1'b0;
        base     = m;
        exponent = e;
        modulus  = n;
        tick();
        tick();
        chk("eoc_low_in_load", int'(eoc), 0);
        clear = 1'b1;
        tick();
        // operands are don't-care once the run has started
        base     = W'($urandom);
        exponent = W'($urandom);
        modulus  = W'($urandom);
        n_en     = 0;
        n_stall  = 0;
        while (!eoc && n_en < BUDGET) begin
            ena = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick();
            if (ena) n_en++;
            else     n_stall++;
        end
        ena = 1'b1;
        chk("latency", n_en, lat_exp);
        chk("result", int'(result), int'(r_exp));
        tick();
        tick();
        tick();
        chk("eoc_held", int'(eoc), 1);
        chk("result_held", int'(result), int'(r_exp));
        last_res = r_exp;
        $display("vec M=%0d E=%0d N=%0d -> result=%0d (exp %0d) latency=%0d (exp %0d) stalls=%0d",
                 m, e, n, result, r_exp, n_en, lat_exp, n_stall);
    endtask

    initial begin
        int n_en;
        bit early;

        vectors     = 0;
        miscompares = 0;
        last_res    = '0;

        vecs[0] = '{m:8'd88,  e:8'd7,   n:8'd187, r:8'd11, lat:96};
        vecs[1] = '{m:8'd5,   e:8'd0,   n:8'd7,   r:8'd1,  lat:72};
        vecs[2] = '{m:8'd0,   e:8'd3,   n:8'd1,   r:8'd0,  lat:88};
        vecs[3] = '{m:8'd200, e:8'd3,   n:8'd187, r:8'd0,  lat:0};
        vecs[4] = '{m:8'd5,   e:8'd3,   n:8'd0,   r:8'd0,  lat:0};
        vecs[5] = '{m:8'd2,   e:8'd10,  n:8'd187, r:8'd89, lat:88};
        vecs[6] = '{m:8'd3,   e:8'd5,   n:8'd7,   r:8'd5,  lat:88};
        vecs[7] = '{m:8'd6,   e:8'd255, n:8'd13,  r:8'd8,  lat:136};
        vecs[8] = '{m:8'd186, e:8'd2,   n:8'd187, r:8'd1,  lat:80};
        vecs[9] = '{m:8'd187, e:8'd2,   n:8'd187, r:8'd0,  lat:0};

        rstb     = 1'b0;
        ena      = 1'b0;
        en       = 1'b0;
        clear    = 1'b0;
        base     = '0;
        exponent = '0;
        modulus  = '0;
        #12;
        chk("reset_eoc", int'(eoc), 0);
        chk("reset_result", int'(result), 0);
        rstb = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i].m, vecs[i].e, vecs[i].n, vecs[i].r, vecs[i].lat, 1'b0);
        end

        // en drop after a completed run: eoc falls, result kept
        run_vec(8'd11, 8'd23, 8'd187, 8'd88, 104, 1'b0);
        en = 1'b0;
        tick();
        chk("en_drop_eoc", int'(eoc), 0);
        chk("en_drop_result", int'(result), 88);
        $display("seq en_drop: eoc=%0d result=%0d", eoc, result);

        // abort mid-run by dropping clear, reload and rerun
        en       = 1'b1;
        clear    = 1'b0;
        base     = 8'd88;
        exponent = 8'd7;
        modulus  = 8'd187;
        tick();
        tick();
        clear = 1'b1;
        tick();
        early = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (eoc) early = 1'b1;
        end
        clear    = 1'b0;
        base     = 8'd2;
        exponent = 8'd10;
        tick();
        tick();
        if (eoc) early = 1'b1;
        chk("abort_no_eoc", int'(early), 0);
        chk("abort_result_kept", int'(result), int'(last_res));
        clear = 1'b1;
        tick();
        n_en = 0;
        while (!eoc && n_en < BUDGET) begin
            tick();
            n_en++;
        end
        chk("abort_latency", n_en, 88);
        chk("abort_result", int'(result), 89);
        last_res = 8'd89;
        $display("seq abort/reload: result=%0d latency=%0d", result, n_en);

        // random ena stalls: enabled-cycle latency unchanged
        run_vec(8'd88, 8'd7, 8'd187, 8'd11, 96, 1'b1);

        // async reset in the middle of a run
        clear    = 1'b0;
        base     = 8'd88;
        exponent = 8'd7;
        modulus  = 8'd187;
        tick();
        tick();
        clear = 1'b1;
        for (int c = 0; c < 50; c++) tick();
        chk("midrun_result_kept", int'(result), 11);
        #2;
        rstb = 1'b0;
        #1;
        chk("midrun_reset_eoc", int'(eoc), 0);
        chk("midrun_reset_result", int'(result), 0);
        $display("seq midrun reset: eoc=%0d result=%0d", eoc, result);
        rstb = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
